// File: rtl/contador_ascendente_modular.sv
// Up counter with programmable modulus (limit+1), synchronous load, terminal-count pulse and wrap counter.
// Optional feature: define CONTADOR_SATURATE_EN to hold at limit instead of wrapping to 0.
module contador_ascendente_modular #(
    parameter int width = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [width-1:0] load_val,
    input  logic [width-1:0] limit,
    output logic [width-1:0] y,
    output logic             tc,
    output logic [7:0]       wraps
);

    localparam logic [width-1:0] one = {{(width-1){1'b0}}, 1'b1};

    logic [width-1:0] y_next;
    logic             tc_next;
    logic [7:0]       wraps_next;

    function automatic logic [width-1:0] clamp_to_limit(
        input logic [width-1:0] value,
        input logic [width-1:0] lim
    );
        return (value > lim) ? lim : value;
    endfunction

    function automatic logic [7:0] bump_wraps(input logic [7:0] count);
        // Free-running 8-bit count: 255 rolls over to 0 on purpose.
        return count + 8'd1;
    endfunction

    always_comb begin
        y_next     = y;
        tc_next    = 1'b0;
        wraps_next = wraps;
        if (load) begin
            y_next = clamp_to_limit(load_val, limit);
        end else if (en) begin
`ifdef CONTADOR_SATURATE_EN
            // Terminal event fires once, on the edge that first lands on limit.
            if (y < limit) begin
                y_next = y + one;
                if ((y + one) == limit) begin
                    tc_next    = 1'b1;
                    wraps_next = bump_wraps(wraps);
                end
            end else if (y > limit) begin
                y_next     = limit;
                tc_next    = 1'b1;
                wraps_next = bump_wraps(wraps);
            end
`else
            // y >= limit also covers limit lowered below the current count.
            if (y < limit) begin
                y_next = y + one;
            end else begin
                y_next     = '0;
                tc_next    = 1'b1;
                wraps_next = bump_wraps(wraps);
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            y     <= '0;
            tc    <= 1'b0;
            wraps <= 8'd0;
        end else begin
            y     <= y_next;
            tc    <= tc_next;
            wraps <= wraps_next;
        end
    end

endmodule

// File: tb/tb_contador_ascendente_modular.sv
// Self-checking bench for contador_ascendente_modular (width=4); vectors plus hand-written corner sequences.
module tb_contador_ascendente_modular;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset, en, load;
    logic [W-1:0] load_val, limit;
    logic [W-1:0] y;
    logic         tc;
    logic [7:0]   wraps;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic       en;
        logic       ld;
        logic [3:0] lv;
        logic [3:0] lim;
        logic [3:0] ey;
        logic       etc;
        logic [7:0] ew;
        string      name;
    } vec_t;

    typedef struct {
        logic [3:0] ey;
        logic       etc;
        logic [7:0] ew;
        string      name;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    contador_ascendente_modular #(.width(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .load    (load),
        .load_val(load_val),
        .limit   (limit),
        .y       (y),
        .tc      (tc),
        .wraps   (wraps)
    );

    always #50 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic e, input logic l, input int lv, input int lim,
                                input int ey, input logic etc, input int ew, input string name);
        vec_t v;
        v.rst = r; v.en = e; v.ld = l;
        v.lv = 4'(lv); v.lim = 4'(lim);
        v.ey = 4'(ey); v.etc = etc; v.ew = 8'(ew);
        v.name = name;
        return v;
    endfunction

    task automatic cmp(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Drive one edge's inputs, queue the expected result, then check it one edge later.
    task automatic step(input vec_t v);
        exp_t e;
        exp_t got;
        @(negedge clk);
        reset = v.rst; en = v.en; load = v.ld; load_val = v.lv; limit = v.lim;
        e.ey = v.ey; e.etc = v.etc; e.ew = v.ew; e.name = v.name;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            cmp("scoreboard_empty", 0, 1);
        end else begin
            got = sb.pop_front();
            cmp({got.name, ".y"}, int'(y), int'(got.ey));
            cmp({got.name, ".tc"}, int'(tc), int'(got.etc));
            cmp({got.name, ".wraps"}, int'(wraps), int'(got.ew));
        end
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; load = 1'b0; load_val = '0; limit = '0;

        // Behaviour shared by both terminal modes.
        tbl.push_back(mk(1, 0, 0, 0, 15, 0, 0, 0, "reset"));
        tbl.push_back(mk(0, 1, 0, 0, 15, 1, 0, 0, "count1"));
        tbl.push_back(mk(0, 1, 0, 0, 15, 2, 0, 0, "count2"));
        tbl.push_back(mk(0, 1, 0, 0, 15, 3, 0, 0, "count3"));
        tbl.push_back(mk(1, 1, 1, 9, 15, 0, 0, 0, "reset_over_load_en"));
        tbl.push_back(mk(0, 0, 1, 3, 9, 3, 0, 0, "load3"));
        tbl.push_back(mk(0, 1, 1, 12, 9, 9, 0, 0, "load_clamped"));
        tbl.push_back(mk(0, 1, 1, 7, 9, 7, 0, 0, "load_in_range"));
        tbl.push_back(mk(0, 0, 0, 0, 9, 7, 0, 0, "hold"));
        tbl.push_back(mk(0, 0, 1, 6, 15, 6, 0, 0, "load6"));
        tbl.push_back(mk(1, 1, 0, 0, 15, 0, 0, 0, "midcount_reset"));
        tbl.push_back(mk(0, 1, 0, 0, 15, 1, 0, 0, "resume_after_reset"));
        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

`ifdef CONTADOR_SATURATE_EN
        step(mk(1, 0, 0, 0, 3, 0, 0, 0, "sat_reset"));
        step(mk(0, 1, 0, 0, 3, 1, 0, 0, "sat1"));
        step(mk(0, 1, 0, 0, 3, 2, 0, 0, "sat2"));
        step(mk(0, 1, 0, 0, 3, 3, 1, 1, "sat_reach"));
        step(mk(0, 1, 0, 0, 3, 3, 0, 1, "sat_hold"));
        step(mk(0, 1, 0, 0, 3, 3, 0, 1, "sat_hold2"));
        step(mk(0, 0, 1, 9, 15, 9, 0, 1, "sat_load9"));
        step(mk(0, 1, 0, 0, 4, 4, 1, 2, "sat_limit_lowered"));
        step(mk(0, 1, 0, 0, 4, 4, 0, 2, "sat_limit_lowered_hold"));
`else
        // Wrap at full range.
        step(mk(0, 0, 1, 15, 15, 15, 0, 0, "load15"));
        step(mk(0, 1, 0, 0, 15, 0, 1, 1, "wrap"));
        step(mk(0, 1, 0, 0, 15, 1, 0, 1, "after_wrap"));
        step(mk(0, 0, 0, 0, 15, 1, 0, 1, "hold_clears_tc"));

        // Modulus 6 for 12 edges from 0.
        step(mk(1, 0, 0, 0, 5, 0, 0, 0, "mod_reset"));
        for (int i = 1; i <= 12; i++) begin
            int ey;
            ey = i % 6;
            step(mk(0, 1, 0, 0, 5, ey, (ey == 0), i / 6, $sformatf("mod6_edge%0d", i)));
        end

        // Limit lowered below the current count, then load after a terminal pulse.
        step(mk(0, 0, 1, 10, 15, 10, 0, 2, "load10"));
        step(mk(0, 1, 0, 0, 4, 0, 1, 3, "limit_lowered"));
        step(mk(0, 1, 1, 2, 4, 2, 0, 3, "load_clears_tc"));

        // limit=0: every enabled edge is terminal.
        step(mk(0, 1, 0, 0, 0, 0, 1, 4, "limit0_a"));
        step(mk(0, 1, 0, 0, 0, 0, 1, 5, "limit0_b"));
        step(mk(0, 0, 0, 0, 0, 0, 0, 5, "limit0_hold"));

        // Wrap counter rolls over after 256 terminal events.
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, "roll_reset"));
        for (int i = 1; i <= 257; i++) begin
            step(mk(0, 1, 0, 0, 0, 0, 1, i % 256, $sformatf("roll%0d", i)));
        end
`endif

        cmp("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
